timer_bank: RTL and testbench

Multi-channel programmable timer peripheral on the CPU's memory-mapped bus, the successor to the single-channel counter. Provides `NUM_CH` independent down-counters of `WIDTH` bits, each supporting one-shot, auto-reload and free-running modes. Each channel has its own maskable, write-1-to-clear interrupt pending bit, and a combined `irq` line drives the controller's interrupt input. Register reads are combinational, matching the multi-cycle datapath's write-back mux.

---
 rtl/timer_bank.sv | 219 +++++++++++++++++++++
 tb/tb_timer_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: multi-channel programmable down-counter peripheral on a
// memory-mapped bus.
//
// Each of NUM_CH channels has four registers: CTRL, PRESET, COUNT and
// STATUS. A channel runs in one of three modes: one-shot, auto-reload or
// free-running up-count. Each channel has a maskable, write-1-to-clear
// pending bit.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high reset
//   we       - write strobe, sampled at the rising edge
//   addr     - byte address: [31:8] bank, [7:4] channel, [3:2] register
//   din      - write data (only din[WIDTH-1:0] is stored for PRESET)
//   dout     - combinational read data for addr (zero-extended)
//   irq      - OR of irq_vec
//   irq_vec  - per-channel pending & IM
module timer_bank #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2
  } state_t;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESET   = 2'd1;
  localparam logic [1:0] REG_COUNT    = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
  localparam logic [1:0] MODE_FREE    = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  state_t           state_q  [NUM_CH];
  state_t           state_d  [NUM_CH];
  logic             en_q     [NUM_CH];
  logic             en_d     [NUM_CH];
  logic [1:0]       mode_q   [NUM_CH];
  logic [1:0]       mode_d   [NUM_CH];
  logic             im_q     [NUM_CH];
  logic             im_d     [NUM_CH];
  logic             pend_q   [NUM_CH];
  logic             pend_d   [NUM_CH];
  logic [WIDTH-1:0] preset_q [NUM_CH];
  logic [WIDTH-1:0] preset_d [NUM_CH];
  logic [WIDTH-1:0] count_q  [NUM_CH];
  logic [WIDTH-1:0] count_d  [NUM_CH];

  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_preset;
  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0] set_pend;
  logic              bank_hit;
  logic [3:0]        ch_sel;
  logic [1:0]        reg_sel;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign bank_hit    = (addr[31:8] == BASE_ADDR[31:8]);
  assign ch_sel      = addr[7:4];
  assign reg_sel     = addr[3:2];
  // Byte-offset bits and upper data bits have no function here.
  assign unused_bits = ^{addr[1:0], din};

  // Address decode: channel indices >= NUM_CH never match, so they are inert.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i]    = bank_hit && (ch_sel == 4'(i));
      wr_ctrl[i]   = we && ch_hit[i] && (reg_sel == REG_CTRL);
      wr_preset[i] = we && ch_hit[i] && (reg_sel == REG_PRESET);
      wr_status[i] = we && ch_hit[i] && (reg_sel == REG_STATUS);
    end
  end

  // Per-channel next-state: register writes, counter FSM and pending bit.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      en_d[i]     = en_q[i];
      mode_d[i]   = mode_q[i];
      im_d[i]     = im_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
      set_pend[i] = 1'b0;

      if (wr_ctrl[i]) begin
        en_d[i]   = din[0];
        mode_d[i] = din[2:1];
        im_d[i]   = din[3];
      end else begin
        en_d[i]   = en_q[i];
      end

      if (wr_preset[i]) begin
        preset_d[i] = din[WIDTH-1:0];
      end else begin
        preset_d[i] = preset_q[i];
      end

      // The FSM acts on the mode held in the register, so a mode written
      // this cycle only takes effect from the next cycle.
      case (state_q[i])
        ST_IDLE: begin
          if (wr_ctrl[i] && din[0] && (din[2:1] != MODE_RSVD)) begin
            state_d[i] = ST_LOAD;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_LOAD: begin
          count_d[i] = (mode_q[i] == MODE_FREE) ? '0 : preset_q[i];
          state_d[i] = ST_CNT;
        end
        ST_CNT: begin
          case (mode_q[i])
            MODE_ONESHOT, MODE_RELOAD: begin
              if (count_q[i] != '0) begin
                count_d[i] = count_q[i] - WIDTH'(1);
              end else begin
                set_pend[i] = 1'b1;
                if (mode_q[i] == MODE_ONESHOT) begin
                  // Completion clears EN even if CTRL is written this cycle.
                  en_d[i]    = 1'b0;
                  state_d[i] = ST_IDLE;
                end else begin
                  count_d[i] = preset_q[i];
                end
              end
            end
            MODE_FREE: count_d[i] = count_q[i] + WIDTH'(1);
            default:   state_d[i] = ST_IDLE;
          endcase
        end
        default: state_d[i] = ST_IDLE;
      endcase

      // Disabling a running channel freezes COUNT at its present value.
      if (wr_ctrl[i] && !din[0] && (state_q[i] != ST_IDLE)) begin
        state_d[i] = ST_IDLE;
        count_d[i] = count_q[i];
      end else begin
        state_d[i] = state_d[i];
      end

      // A set event wins over a simultaneous write-1-to-clear.
      if (set_pend[i]) begin
        pend_d[i] = 1'b1;
      end else if (wr_status[i] && din[0]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        state_q[i]  <= ST_IDLE;
        en_q[i]     <= 1'b0;
        mode_q[i]   <= 2'd0;
        im_q[i]     <= 1'b0;
        pend_q[i]   <= 1'b0;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
      end else begin
        state_q[i]  <= state_d[i];
        en_q[i]     <= en_d[i];
        mode_q[i]   <= mode_d[i];
        im_q[i]     <= im_d[i];
        pend_q[i]   <= pend_d[i];
        preset_q[i] <= preset_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    dout   = 32'd0;
    rd_val = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (reg_sel)
        REG_CTRL:   rd_val = {28'd0, im_q[i], mode_q[i], en_q[i]};
        REG_PRESET: rd_val = 32'(preset_q[i]);
        REG_COUNT:  rd_val = 32'(count_q[i]);
        REG_STATUS: rd_val = {31'd0, pend_q[i]};
        default:    rd_val = 32'd0;
      endcase
      dout = dout | (ch_hit[i] ? rd_val : 32'd0);
    end
  end

  // Interrupt outputs, built directly from flops with no extra stage.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      irq_vec[i] = pend_q[i] & im_q[i];
    end
    irq = |irq_vec;
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: self-checking bench for timer_bank (NUM_CH=2, WIDTH=4).
// Register reads push their expected value into a scoreboard queue; the
// value is popped and compared once dout has settled.
module tb_timer_bank;

  localparam int unsigned NCH  = 2;
  localparam int unsigned W    = 4;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic           clk;
  logic           reset;
  logic           we;
  logic [31:0]    addr;
  logic [31:0]    din;
  logic [31:0]    dout;
  logic           irq;
  logic [NCH-1:0] irq_vec;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  timer_bank #(
    .NUM_CH   (NCH),
    .WIDTH    (W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .irq    (irq),
    .irq_vec(irq_vec)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want normal end");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ra(input int ch, input int r);
    return BASE + 32'(ch * 16 + r * 4);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick(1);
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      check_val(tag_q.pop_front(), dout, exp_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'd0;
    din   = 32'd0;
    tick(2);
    reset = 1'b0;

    // Reset state, unmapped channel and out-of-bank reads.
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd($sformatf("rst_c%0d_r%0d", c, r), ra(c, r), 32'd0);
      end
    end
    for (int r = 0; r < 4; r++) begin
      rd($sformatf("rst_c5_r%0d", r), ra(5, r), 32'd0);
    end
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_vec", 32'(irq_vec), 32'd0);

    // Writes outside the bank or to a missing channel have no effect.
    wr(32'h0000_8004, 32'd7);
    wr(ra(5, 1), 32'd7);
    rd("oob_rd", 32'h0000_8004, 32'd0);
    rd("oob_p0", ra(0, 1), 32'd0);
    rd("oob_p1", ra(1, 1), 32'd0);

    // Ch0 one-shot, PRESET=3, IM=1.
    wr(ra(0, 1), 32'd3);
    rd("os_preset", ra(0, 1), 32'd3);
    wr(ra(0, 0), 32'h9);
    for (int k = 3; k >= 0; k--) begin
      tick(1);
      rd($sformatf("os_cnt%0d", k), ra(0, 2), 32'(k));
    end
    check_val("os_irq_early", 32'(irq), 32'd0);
    tick(1);
    check_val("os_irq", 32'(irq), 32'd1);
    rd("os_ctrl", ra(0, 0), 32'h8);
    rd("os_stat", ra(0, 3), 32'd1);
    rd("os_cnt_hold", ra(0, 2), 32'd0);
    wr(ra(0, 3), 32'd1);
    check_val("os_w1c_irq", 32'(irq), 32'd0);
    rd("os_w1c_stat", ra(0, 3), 32'd0);
    wr(ra(0, 2), 32'd5);
    rd("cnt_ro", ra(0, 2), 32'd0);

    // Ch1 auto-reload, PRESET=2, IM=1: pending every 3 cycles.
    wr(ra(1, 1), 32'd2);
    wr(ra(1, 0), 32'hB);
    tick(3);
    rd("ar_cnt0", ra(1, 2), 32'd0);
    check_val("ar_irq0", 32'(irq), 32'd0);
    tick(1);
    check_val("ar_irq1", 32'(irq), 32'd1);
    check_val("ar_vec1", 32'(irq_vec), 32'd2);
    rd("ar_reload", ra(1, 2), 32'd2);
    wr(ra(1, 3), 32'd1);
    rd("ar_clr", ra(1, 3), 32'd0);
    rd("ar_cnt1", ra(1, 2), 32'd1);
    tick(1);
    rd("ar_still0", ra(1, 3), 32'd0);
    wr(ra(1, 3), 32'd1);
    rd("ar_setwins", ra(1, 3), 32'd1);
    rd("ar_reload2", ra(1, 2), 32'd2);
    check_val("ar_irq2", 32'(irq), 32'd1);
    wr(ra(1, 0), 32'd0);
    rd("ar_stop", ra(1, 2), 32'd2);
    tick(2);
    rd("ar_frozen", ra(1, 2), 32'd2);
    rd("ar_ctrl", ra(1, 0), 32'd0);
    wr(ra(1, 3), 32'd1);
    rd("ar_clr2", ra(1, 3), 32'd0);

    // Ch0 free-running, 4-bit wrap, then freeze at 7.
    wr(ra(0, 0), 32'h5);
    tick(1);
    rd("fr_0", ra(0, 2), 32'd0);
    for (int k = 1; k < 16; k++) begin
      tick(1);
      rd($sformatf("fr_%0d", k), ra(0, 2), 32'(k));
    end
    tick(1);
    rd("fr_wrap", ra(0, 2), 32'd0);
    rd("fr_nopend", ra(0, 3), 32'd0);
    tick(7);
    rd("fr_7", ra(0, 2), 32'd7);
    wr(ra(0, 0), 32'h4);
    rd("fr_frz", ra(0, 2), 32'd7);
    tick(2);
    rd("fr_frz2", ra(0, 2), 32'd7);
    rd("fr_ctrl", ra(0, 0), 32'h4);
    rd("fr_nopend2", ra(0, 3), 32'd0);

    // Ch0 one-shot with IM=0, then unmask.
    wr(ra(0, 1), 32'd1);
    wr(ra(0, 0), 32'h1);
    tick(3);
    rd("im0_stat", ra(0, 3), 32'd1);
    check_val("im0_irq", 32'(irq), 32'd0);
    rd("im0_ctrl", ra(0, 0), 32'd0);
    wr(ra(0, 0), 32'h8);
    check_val("im1_irq", 32'(irq), 32'd1);
    check_val("im1_vec", 32'(irq_vec), 32'd1);
    wr(ra(0, 3), 32'd1);
    check_val("im1_clr", 32'(irq), 32'd0);

    // Width truncation and reset mid-count.
    wr(ra(1, 1), 32'hFFFF_FFFA);
    rd("trunc", ra(1, 1), 32'hA);
    wr(ra(0, 0), 32'h5);
    wr(ra(1, 0), 32'hB);
    tick(7);
    rd("mid_cnt4", ra(1, 2), 32'd4);
    reset = 1'b1;
    we    = 1'b1;
    addr  = ra(0, 1);
    din   = 32'd5;
    tick(1);
    reset = 1'b0;
    we    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd($sformatf("mr_c%0d_r%0d", c, r), ra(c, r), 32'd0);
      end
    end
    check_val("mr_irq", 32'(irq), 32'd0);
    tick(3);
    rd("mr_idle1", ra(1, 2), 32'd0);
    rd("mr_idle0", ra(0, 2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
